// File: rtl/jt7759_rom_buf_if.sv
// rtl/jt7759_rom_buf_if.sv - controller byte port and memory word port of the JT7759 ROM buffer
interface jt7759_rom_buf_if;
  logic        rom_cs;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_ok;
  logic        mem_cs;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_ok;

  modport slave (
    input  rom_cs, rom_addr, mem_data, mem_ok,
    output rom_data, rom_ok, mem_cs, mem_addr
  );

  modport master (
    output rom_cs, rom_addr, mem_data, mem_ok,
    input  rom_data, rom_ok, mem_cs, mem_addr
  );
endinterface

// File: rtl/jt7759_rom_buf.sv
// rtl/jt7759_rom_buf.sv - two-line word cache with sequential prefetch for the JT7759 ROM port
module jt7759_rom_buf (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  jt7759_rom_buf_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_PREFETCH} state_t;

  state_t      state_q;
  logic [1:0]  valid_q;
  logic [15:0] tag_q  [2];
  logic [15:0] data_q [2];
  logic        lru_q;
  logic        vic_q;
  logic        flushed_q;
  logic [7:0]  rom_data_q;
  logic        rom_ok_q;
  logic        mem_cs_q;
  logic [15:0] mem_addr_q;

  logic [15:0] wa;
  logic [15:0] nwa;
  logic [1:0]  live;
  logic [1:0]  hit_vec;
  logic [1:0]  next_vec;
  logic        hit;
  logic        hit_line;
  logic        next_cached;
  logic        fill_keep;
  logic [15:0] hit_word;
  logic [7:0]  rom_data_d;
  logic        lru_d;

  assign wa  = bus.rom_addr[16:1];
  assign nwa = wa + 16'd1;

  always_comb begin
    // a flush hides both lines already in the cycle it is raised
    live = valid_q & ~{2{flush}};
    hit_vec  = 2'b00;
    next_vec = 2'b00;
    for (int i = 0; i < 2; i++) begin
      hit_vec[i]  = live[i] && (tag_q[i] == wa);
      next_vec[i] = live[i] && (tag_q[i] == nwa);
    end
    hit         = |hit_vec;
    hit_line    = ~hit_vec[0];
    next_cached = |next_vec;
    hit_word    = data_q[hit_line];
    rom_data_d  = bus.rom_addr[0] ? hit_word[15:8] : hit_word[7:0];
    lru_d       = (bus.rom_cs && hit) ? ~hit_line : lru_q;
    fill_keep   = bus.mem_ok && !flush && !flushed_q;
  end

  assign bus.rom_data = rom_data_q;
  assign bus.rom_ok   = rom_ok_q;
  assign bus.mem_cs   = mem_cs_q;
  assign bus.mem_addr = mem_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      valid_q    <= 2'b00;
      tag_q[0]   <= '0;
      tag_q[1]   <= '0;
      data_q[0]  <= '0;
      data_q[1]  <= '0;
      lru_q      <= 1'b0;
      vic_q      <= 1'b0;
      flushed_q  <= 1'b0;
      rom_data_q <= '0;
      rom_ok_q   <= 1'b0;
      mem_cs_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      rom_ok_q <= bus.rom_cs & hit;
      if (hit) rom_data_q <= rom_data_d;
      lru_q <= lru_d;
      if (flush) valid_q <= 2'b00;
      case (state_q)
        ST_IDLE: begin
          if (bus.rom_cs && (!hit || !next_cached)) begin
            mem_cs_q  <= 1'b1;
            flushed_q <= 1'b0;
            if (!hit) begin
              state_q    <= ST_FETCH;
              mem_addr_q <= wa;
              vic_q      <= lru_q;
            end else begin
              // never evict the line the controller is reading from
              state_q    <= ST_PREFETCH;
              mem_addr_q <= nwa;
              vic_q      <= ~hit_line;
            end
          end
        end
        default: begin
          if (flush) flushed_q <= 1'b1;
          if (bus.mem_ok) begin
            state_q  <= ST_IDLE;
            mem_cs_q <= 1'b0;
            if (fill_keep) begin
              valid_q[vic_q] <= 1'b1;
              tag_q[vic_q]   <= mem_addr_q;
              data_q[vic_q]  <= bus.mem_data;
              if (state_q == ST_FETCH) lru_q <= ~vic_q;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_jt7759_rom_buf.sv
// tb/tb_jt7759_rom_buf.sv - self-checking bench for jt7759_rom_buf
module tb_jt7759_rom_buf;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  jt7759_rom_buf_if bus();

  jt7759_rom_buf dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          gen = 0;
  int          memlat = 1;
  int          mcnt = 0;
  int          wait_cnt = 0;
  logic        was_mcs = 1'b0;
  logic [15:0] was_maddr = '0;
  logic [16:0] last_addr = '0;
  logic [15:0] req_log[$];

  typedef struct {
    logic        cs;
    logic [16:0] addr;
    logic        x_ok;
    logic [7:0]  x_data;
    logic        x_mcs;
    logic [15:0] x_maddr;
  } vec_t;

  vec_t tab[11];

  // ROM image: contents depend on the word address and on how many flushes have happened
  function automatic logic [15:0] mem_word(input logic [15:0] a, input int g);
    logic [15:0] m;
    m = a * 16'h3B1D;
    m = m + 16'(g) * 16'h5A5A;
    return m ^ 16'hA55A;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [16:0] a, input int g);
    logic [15:0] w;
    w = mem_word(a[16:1], g);
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // one clock; checks the protocol rules and runs the memory responder
  task automatic step();
    logic [16:0] a_addr;
    logic        a_cs;
    logic        a_fl;
    logic        a_mok;
    a_addr = bus.rom_addr;
    a_cs   = bus.rom_cs;
    a_fl   = flush;
    a_mok  = bus.mem_ok;
    @(posedge clk);
    #1;
    if (a_fl) gen++;
    if (bus.rom_ok) begin
      check_eq("ok_cond", {30'd0, a_cs, a_fl}, 32'd2);
      check_eq("rom_data", bus.rom_data, mem_byte(a_addr, gen));
    end
    if (was_mcs && !a_mok) begin
      check_eq("mem_hold_cs", bus.mem_cs, 1);
      check_eq("mem_hold_addr", bus.mem_addr, was_maddr);
    end
    if (was_mcs && a_mok) check_eq("mem_gap", bus.mem_cs, 0);
    if (bus.mem_cs && !was_mcs) begin
      check_eq("req_needs_cs", a_cs, 1);
      req_log.push_back(bus.mem_addr);
    end
    if (!a_cs || bus.rom_ok || a_addr != last_addr) wait_cnt = 0;
    else wait_cnt++;
    last_addr = a_addr;
    if (wait_cnt >= 40) begin
      checks++;
      errors++;
      $display("FAIL stall: address 0x%0h waited %0d cycles, expected under 40", a_addr, wait_cnt);
      wait_cnt = 0;
    end
    was_mcs   = bus.mem_cs;
    was_maddr = bus.mem_addr;
    if (bus.mem_cs) begin
      mcnt++;
      if (mcnt > memlat) begin
        bus.mem_ok   = 1'b1;
        bus.mem_data = mem_word(bus.mem_addr, gen);
      end else begin
        bus.mem_ok   = 1'b0;
        bus.mem_data = 16'($urandom);
      end
    end else begin
      mcnt       = 0;
      bus.mem_ok = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.rom_cs   = 1'b0;
    bus.rom_addr = '0;
    flush        = 1'b0;
    bus.mem_ok   = 1'b0;
    bus.mem_data = '0;
    mcnt         = 0;
    was_mcs      = 1'b0;
    was_maddr    = '0;
    wait_cnt     = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_req_since(input int n0, input logic [15:0] exp, input string name);
    int n;
    n = 0;
    while (req_log.size() <= n0 && n < 40) begin
      step();
      n++;
    end
    if (req_log.size() <= n0) begin
      checks++;
      errors++;
      $display("FAIL %s: no memory request within 40 cycles, expected address 0x%0h", name, exp);
    end else begin
      check_eq(name, req_log[n0], exp);
    end
  endtask

  task automatic wait_req(input logic [15:0] exp, input string name);
    wait_req_since(req_log.size(), exp, name);
  endtask

  task automatic wait_ok(input string name);
    int n;
    n = 0;
    step();
    while (!bus.rom_ok && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (!bus.rom_ok) begin
      errors++;
      $display("FAIL %s: rom_ok=0 after 40 cycles, expected 1", name);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          n0;
    int          cnt;
    int          r;
    int          hold;
    logic [16:0] ra;

    tab[0]  = '{1'b1, 17'h00000, 1'b0, 8'h00, 1'b1, 16'h0000};
    tab[1]  = '{1'b1, 17'h00000, 1'b0, 8'h00, 1'b1, 16'h0000};
    tab[2]  = '{1'b1, 17'h00000, 1'b0, 8'h00, 1'b1, 16'h0000};
    tab[3]  = '{1'b1, 17'h00000, 1'b0, 8'h00, 1'b1, 16'h0000};
    tab[4]  = '{1'b1, 17'h00000, 1'b0, 8'h00, 1'b0, 16'h0000};
    tab[5]  = '{1'b1, 17'h00000, 1'b1, 8'h5A, 1'b1, 16'h0001};
    tab[6]  = '{1'b1, 17'h00000, 1'b1, 8'h5A, 1'b1, 16'h0001};
    tab[7]  = '{1'b1, 17'h00000, 1'b1, 8'h5A, 1'b1, 16'h0001};
    tab[8]  = '{1'b1, 17'h00000, 1'b1, 8'h5A, 1'b1, 16'h0001};
    tab[9]  = '{1'b1, 17'h00001, 1'b1, 8'hA5, 1'b0, 16'h0001};
    tab[10] = '{1'b1, 17'h00002, 1'b1, 8'h47, 1'b1, 16'h0002};

    // reset values, then first miss / fill / prefetch and hits, memory latency 3
    memlat = 3;
    do_reset();
    check_eq("rst_rom_data", bus.rom_data, 8'h00);
    check_eq("rst_rom_ok", bus.rom_ok, 0);
    check_eq("rst_mem_cs", bus.mem_cs, 0);
    check_eq("rst_mem_addr", bus.mem_addr, 16'h0000);
    for (int i = 0; i < 11; i++) begin
      bus.rom_cs   = tab[i].cs;
      bus.rom_addr = tab[i].addr;
      step();
      check_eq($sformatf("tab%0d_ok", i), bus.rom_ok, tab[i].x_ok);
      if (tab[i].x_ok) check_eq($sformatf("tab%0d_data", i), bus.rom_data, tab[i].x_data);
      check_eq($sformatf("tab%0d_mem_cs", i), bus.mem_cs, tab[i].x_mcs);
      check_eq($sformatf("tab%0d_mem_addr", i), bus.mem_addr, tab[i].x_maddr);
    end

    // prefetch wraps from word 0xFFFF to word 0
    memlat = 1;
    do_reset();
    bus.rom_cs   = 1'b1;
    bus.rom_addr = 17'h1FFFE;
    wait_req(16'hFFFF, "wrap_fetch");
    wait_req(16'h0000, "wrap_prefetch");

    // demand miss during a slow prefetch is served after it; hit line survives the prefetch
    memlat = 5;
    do_reset();
    bus.rom_cs   = 1'b1;
    bus.rom_addr = 17'h00004;
    wait_req(16'h0002, "dp_fetch");
    wait_req(16'h0003, "dp_prefetch");
    bus.rom_addr = 17'h00100;
    wait_req(16'h0080, "dp_demand");
    wait_ok("dp_fill");
    bus.rom_addr = 17'h00004;
    step();
    step();
    check_eq("dp_keep_ok", bus.rom_ok, 1);
    check_eq("dp_keep_data", bus.rom_data, mem_byte(17'h00004, gen));

    // demand for the word being prefetched needs no second fetch
    memlat = 4;
    do_reset();
    bus.rom_cs   = 1'b1;
    bus.rom_addr = 17'h00000;
    wait_req(16'h0000, "pd_fetch");
    wait_req(16'h0001, "pd_prefetch");
    bus.rom_addr = 17'h00002;
    n0 = req_log.size();
    wait_ok("pd_ok");
    cnt = 0;
    for (int i = n0; i < req_log.size(); i++) if (req_log[i] == 16'h0001) cnt++;
    check_eq("pd_no_refetch", cnt, 0);
    check_eq("pd_data", bus.rom_data, mem_byte(17'h00002, gen));

    // flush together with mem_ok discards the fill and the word is fetched again
    memlat = 2;
    do_reset();
    bus.rom_cs   = 1'b1;
    bus.rom_addr = 17'h00010;
    wait_req(16'h0008, "fl_fetch");
    n0 = 0;
    while (!bus.mem_ok && n0 < 20) begin
      step();
      n0++;
    end
    check_eq("fl_mem_ok_seen", bus.mem_ok, 1);
    n0 = req_log.size();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("fl_ok_0", bus.rom_ok, 0);
    step();
    check_eq("fl_ok_1", bus.rom_ok, 0);
    wait_req_since(n0, 16'h0008, "fl_refetch");
    wait_ok("fl_refill");
    check_eq("fl_data", bus.rom_data, mem_byte(17'h00010, gen));

    // asynchronous reset in the middle of a fetch
    memlat = 1;
    do_reset();
    bus.rom_cs   = 1'b1;
    bus.rom_addr = 17'h00000;
    wait_ok("ar_first");
    memlat = 8;
    bus.rom_addr = 17'h00200;
    wait_req(16'h0100, "ar_fetch");
    bus.rom_addr = 17'h00000;
    step();
    step();
    check_eq("ar_pre_ok", bus.rom_ok, 1);
    check_eq("ar_pre_mem_cs", bus.mem_cs, 1);
    rst_n = 1'b0;
    #1;
    check_eq("ar_mem_cs", bus.mem_cs, 0);
    check_eq("ar_rom_ok", bus.rom_ok, 0);
    do_reset();
    memlat = 1;
    bus.rom_cs   = 1'b1;
    bus.rom_addr = 17'h00000;
    n0 = req_log.size();
    step();
    check_eq("ar_after_ok", bus.rom_ok, 0);
    wait_req_since(n0, 16'h0000, "ar_refetch");

    // sequential stream with a wait cycle per byte keeps rom_ok up
    memlat = 2;
    do_reset();
    bus.rom_cs   = 1'b1;
    bus.rom_addr = 17'h00000;
    wait_ok("st_first");
    for (int b = 0; b < 64; b++) begin
      bus.rom_addr = 17'(b);
      step();
      step();
      check_eq($sformatf("stream_ok_%0d", b), bus.rom_ok, 1);
    end

    // random traffic with flushes, checked by the step rules and the ROM image
    do_reset();
    ra = '0;
    for (int op = 0; op < 600; op++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      ra = ra + 17'd1;
      else if (r < 75) ra = 17'($urandom_range(0, 511));
      else if (r < 85) ra = 17'h1FFF8 + 17'($urandom_range(0, 7));
      else             ra = 17'($urandom);
      bus.rom_addr = ra;
      bus.rom_cs   = ($urandom_range(0, 9) != 0);
      memlat       = $urandom_range(0, 4);
      flush        = ($urandom_range(0, 30) == 0);
      hold         = $urandom_range(1, 8);
      for (int h = 0; h < hold; h++) begin
        step();
        flush = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
